warp_xwriteback: RTL

- Scalar integer writeback merger: collects results from the fixed-latency lanes (ALU/logic/shift on lane A, multiplier on lane B) and the variable-latency divider.
- Drives the two register-file write ports (rd1, rd2) from registered outputs.
- Buffers divider results in a small FIFO, which drains into whichever write port is idle.
- Suppresses x0 writes and guarantees rd1 != rd2 on any cycle, which the register file's bypass logic requires.

---
 rtl/warp_xwriteback_pkg.sv | 19 +
 rtl/warp_xwriteback_if.sv | 39 +++
 rtl/warp_xwb_fifo.sv | 48 ++++
 rtl/warp_xwriteback.sv | 130 +++++++++++++
 4 files changed

// File: rtl/warp_xwriteback_pkg.sv
// Shared types and constants for the scalar integer writeback merger.
// Port-select encoding is used by the divider-FIFO drain logic.
package warp_xwriteback_pkg;
    localparam int DIV_DEPTH_DEF = 4;
    localparam int RD_W          = 5;
    localparam int XLEN          = 64;
    localparam int DIV_ENTRY_W   = RD_W + XLEN;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_1    = 2'd1,
        PORT_2    = 2'd2
    } wb_port_e;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } div_entry_t;
endpackage

// File: rtl/warp_xwriteback_if.sv
// Lane/divider inputs and register-file write-port outputs of the writeback merger.
interface warp_xwriteback_if;
    import warp_xwriteback_pkg::*;

    logic            i_a_valid;
    logic [RD_W-1:0] i_a_rd;
    logic [XLEN-1:0] i_a_data;
    logic            i_b_valid;
    logic [RD_W-1:0] i_b_rd;
    logic [XLEN-1:0] i_b_data;
    logic            i_div_valid;
    logic [RD_W-1:0] i_div_rd;
    logic            i_div_rem;
    logic [XLEN-1:0] i_div_quotient;
    logic [XLEN-1:0] i_div_remainder;
    logic            o_div_ready;
    logic            o_rd1_wen;
    logic [RD_W-1:0] o_rd1_addr;
    logic [XLEN-1:0] o_rd1_wdata;
    logic            o_rd2_wen;
    logic [RD_W-1:0] o_rd2_addr;
    logic [XLEN-1:0] o_rd2_wdata;
    logic            o_collision;
    logic            o_overflow;

    modport master (
        output i_a_valid, i_a_rd, i_a_data, i_b_valid, i_b_rd, i_b_data,
               i_div_valid, i_div_rd, i_div_rem, i_div_quotient, i_div_remainder,
        input  o_div_ready, o_rd1_wen, o_rd1_addr, o_rd1_wdata,
               o_rd2_wen, o_rd2_addr, o_rd2_wdata, o_collision, o_overflow
    );

    modport slave (
        input  i_a_valid, i_a_rd, i_a_data, i_b_valid, i_b_rd, i_b_data,
               i_div_valid, i_div_rd, i_div_rem, i_div_quotient, i_div_remainder,
        output o_div_ready, o_rd1_wen, o_rd1_addr, o_rd1_wdata,
               o_rd2_wen, o_rd2_addr, o_rd2_wdata, o_collision, o_overflow
    );
endinterface

// File: rtl/warp_xwb_fifo.sv
// Small synchronous FIFO holding divider results until a write port is free.
// Head is read combinationally so a drain decision can use it in the same cycle.
module warp_xwb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem[wr_ptr_reg] <= i_push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (i_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (i_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = mem[rd_ptr_reg];
    assign o_count = count_reg;
    assign o_full  = (count_reg == CW'(DEPTH));
    assign o_empty = (count_reg == '0);
endmodule

// File: rtl/warp_xwriteback.sv
// Writeback merger: lane A -> port 1, lane B -> port 2, divider results queued
// and drained into an idle port; x0 writes suppressed and port addresses kept distinct.
module warp_xwriteback
    import warp_xwriteback_pkg::*;
#(
    parameter int DIV_DEPTH = DIV_DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    warp_xwriteback_if.slave  wb
);
    localparam int CW = $clog2(DIV_DEPTH) + 1;

    logic             a_wr, b_wr, collision, hold, head_zero;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty, drain_wr;
    logic [CW-1:0]    fifo_count;
    logic [DIV_ENTRY_W-1:0] fifo_head;
    div_entry_t       push_entry, head_entry;
    wb_port_e         drain_port;

    logic             rd1_wen_reg, rd1_wen_next, rd2_wen_reg, rd2_wen_next;
    logic [RD_W-1:0]  rd1_addr_reg, rd1_addr_next, rd2_addr_reg, rd2_addr_next;
    logic [XLEN-1:0]  rd1_data_reg, rd1_data_next, rd2_data_reg, rd2_data_next;
    logic             collision_reg, overflow_reg, overflow_next;

    assign a_wr      = wb.i_a_valid && (wb.i_a_rd != '0);
    assign collision = a_wr && wb.i_b_valid && (wb.i_b_rd == wb.i_a_rd);
    assign b_wr      = wb.i_b_valid && (wb.i_b_rd != '0) && !collision;

    assign push_entry = {wb.i_div_rd, wb.i_div_rem ? wb.i_div_remainder : wb.i_div_quotient};
    assign head_entry = div_entry_t'(fifo_head);
    assign head_zero  = (head_entry.rd == '0);
    // A head whose rd is being written by a lane this cycle must wait, or the ports could alias.
    assign hold       = (a_wr && head_entry.rd == wb.i_a_rd) || (b_wr && head_entry.rd == wb.i_b_rd);

    always_comb begin
        drain_port = PORT_NONE;
        if (!b_wr) begin
            drain_port = PORT_2;
        end else if (!a_wr) begin
            drain_port = PORT_1;
        end
    end

    // x0 entries are discarded without needing a port.
    assign fifo_pop  = !fifo_empty && (head_zero || (drain_port != PORT_NONE && !hold));
    assign drain_wr  = fifo_pop && !head_zero;
    assign fifo_push = wb.i_div_valid && !fifo_full;

    warp_xwb_fifo #(
        .DEPTH (DIV_DEPTH),
        .WIDTH (DIV_ENTRY_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (fifo_push),
        .i_push_data (push_entry),
        .i_pop       (fifo_pop),
        .o_head      (fifo_head),
        .o_count     (fifo_count),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    always_comb begin
        rd1_wen_next  = 1'b0;
        rd1_addr_next = rd1_addr_reg;
        rd1_data_next = rd1_data_reg;
        rd2_wen_next  = 1'b0;
        rd2_addr_next = rd2_addr_reg;
        rd2_data_next = rd2_data_reg;
        if (a_wr) begin
            rd1_wen_next  = 1'b1;
            rd1_addr_next = wb.i_a_rd;
            rd1_data_next = wb.i_a_data;
        end else if (drain_wr && drain_port == PORT_1) begin
            rd1_wen_next  = 1'b1;
            rd1_addr_next = head_entry.rd;
            rd1_data_next = head_entry.data;
        end
        if (b_wr) begin
            rd2_wen_next  = 1'b1;
            rd2_addr_next = wb.i_b_rd;
            rd2_data_next = wb.i_b_data;
        end else if (drain_wr && drain_port == PORT_2) begin
            rd2_wen_next  = 1'b1;
            rd2_addr_next = head_entry.rd;
            rd2_data_next = head_entry.data;
        end
        overflow_next = overflow_reg || (wb.i_div_valid && fifo_full);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd1_wen_reg   <= 1'b0;
            rd1_addr_reg  <= '0;
            rd1_data_reg  <= '0;
            rd2_wen_reg   <= 1'b0;
            rd2_addr_reg  <= '0;
            rd2_data_reg  <= '0;
            collision_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            rd1_wen_reg   <= rd1_wen_next;
            rd1_addr_reg  <= rd1_addr_next;
            rd1_data_reg  <= rd1_data_next;
            rd2_wen_reg   <= rd2_wen_next;
            rd2_addr_reg  <= rd2_addr_next;
            rd2_data_reg  <= rd2_data_next;
            collision_reg <= collision;
            overflow_reg  <= overflow_next;
        end
    end

    // One slot stays free for the divide that may already be in flight.
    assign wb.o_div_ready = (fifo_count < CW'(DIV_DEPTH - 1));
    assign wb.o_rd1_wen   = rd1_wen_reg;
    assign wb.o_rd1_addr  = rd1_addr_reg;
    assign wb.o_rd1_wdata = rd1_data_reg;
    assign wb.o_rd2_wen   = rd2_wen_reg;
    assign wb.o_rd2_addr  = rd2_addr_reg;
    assign wb.o_rd2_wdata = rd2_data_reg;
    assign wb.o_collision = collision_reg;
    assign wb.o_overflow  = overflow_reg;

    no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(wb.i_div_valid && fifo_full));
    ports_distinct: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(rd1_wen_reg && rd2_wen_reg && rd1_addr_reg == rd2_addr_reg));
endmodule
